// File: rtl/instr_loader.sv
// Instruction memory loader: zero-fills a 1 KiB instruction memory, then streams a
// length-prefixed, XOR-checksummed program image into it while holding the core in reset.
module instr_loader (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       mem_we,
  output logic [9:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_dbg
);

  // Byte stream handshake: a byte transfers on a rising clk edge where rx_valid && rx_ready.
  // rx_ready is a function of state only and never looks at rx_valid; rx_data must be stable
  // while rx_valid is high.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LEN_LO = 3'd2,
    LEN_HI = 3'd3,
    DATA   = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } state_t;

  state_t      state;
  state_t      state_nx;

  logic        accept;
  logic [7:0]  len_lo;
  logic [15:0] len_word;
  logic        len_bad;
  logic [8:0]  n_words;
  logic [10:0] byte_count;
  logic [9:0]  idx;
  logic        last_byte;
  logic [7:0]  csum;
  logic        clear_last;

  assign accept     = rx_valid && rx_ready;
  assign len_word   = {rx_data, len_lo};
  assign len_bad    = (len_word == 16'd0) || (len_word > 16'd256);
  assign byte_count = {n_words, 2'b00};
  // 11-bit compare so that N=256 (1024 bytes) ends at index 1023 without wrapping.
  assign last_byte  = (({1'b0, idx} + 11'd1) == byte_count);
  assign clear_last = (mem_addr == 10'd1023);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    cpu_hold = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CLEAR;
      end
      CLEAR: begin
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (clear_last) state_nx = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = LEN_HI;
      end
      LEN_HI: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = len_bad ? ERROR : DATA;
      end
      DATA: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (rx_valid && last_byte) state_nx = CHECK;
      end
      CHECK: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nx = (rx_data == csum) ? DONE : ERROR;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERROR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_nx = CLEAR;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory port is registered: each write appears the cycle after the edge that caused it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= 10'd0;
      mem_wdata <= 8'd0;
      len_lo    <= 8'd0;
      n_words   <= 9'd0;
      idx       <= 10'd0;
      csum      <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            mem_we    <= 1'b1;
            mem_addr  <= 10'd0;
            mem_wdata <= 8'd0;
          end
        end
        CLEAR: begin
          if (clear_last) begin
            csum <= 8'd0;
          end else begin
            mem_we   <= 1'b1;
            mem_addr <= mem_addr + 10'd1;
          end
        end
        LEN_LO: begin
          if (accept) len_lo <= rx_data;
        end
        LEN_HI: begin
          if (accept && !len_bad) begin
            n_words <= len_word[8:0];
            idx     <= 10'd0;
          end
        end
        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= idx;
            mem_wdata <= rx_data;
            idx       <= idx + 10'd1;
            csum      <= csum ^ rx_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: randomized load sessions checked against a memory-image and
// write-sequence model derived from the stream format (length, data bytes, checksum).
module tb_instr_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t wr_log[$];
  int  done_log[$];

  always @(negedge clk) begin : monitor
    wr_t w;
    if (mem_we === 1'b1) begin
      w.cyc  = cyc;
      w.addr = mem_addr;
      w.data = mem_wdata;
      wr_log.push_back(w);
    end
    if (done === 1'b1) done_log.push_back(cyc);
  end

  logic [7:0]  stim_q[$];
  int          acc_q[$];
  int          start_cyc;
  bit          stalled;
  bit          hold_s;
  bit          busy_s;

  logic [17:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          exp_ok;
  int          exp_n;
  logic [7:0]  mem_model [1024];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] fixed_stream [11] = '{8'h02, 8'h00, 8'h01, 8'h14, 8'h00, 8'h91,
                                    8'h02, 8'h28, 8'h00, 8'h91, 8'h3F};

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc, output bit ok);
    rx_data  = b;
    rx_valid = 1'b1;
    ok       = 1'b0;
    acc      = -1;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
      end
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic drive_session(input bit bub, input bit poke, input int nbytes);
    int c;
    bit ok;
    wr_log.delete();
    done_log.delete();
    acc_q.delete();
    stalled = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    hold_s = cpu_hold;
    busy_s = busy;
    if (poke) begin
      repeat (50) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < nbytes; i++) begin
      if (bub && i >= 2) begin
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (poke && i == 6) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      send_byte(stim_q[i], c, ok);
      if (!ok) begin
        stalled = 1'b1;
        break;
      end
      acc_q.push_back(c);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Reference model: what the memory and the write stream must look like for stim_q.
  task automatic build_model();
    int n;
    logic [7:0] x;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int a = 0; a < 1024; a++) begin
      mem_model[a] = 8'h00;
      exp_q.push_back({10'(a), 8'h00});
    end
    n = int'({stim_q[1], stim_q[0]});
    exp_ok = 1'b0;
    exp_n  = 0;
    if (n == 0 || n > 256) return;
    exp_n = 4 * n;
    x = 8'h00;
    for (int k = 0; k < exp_n; k++) begin
      mem_model[k] = stim_q[2 + k];
      x = x ^ stim_q[2 + k];
      exp_q.push_back({10'(k), stim_q[2 + k]});
      exp_cyc_q.push_back((k + 2 < acc_q.size()) ? acc_q[k + 2] + 1 : -1);
    end
    exp_ok = (stim_q[2 + exp_n] == x);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [23:0] outs;
    reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    #2;
    outs = {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error};
    n_cmp++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000000", outs);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    wr_log.delete();
    repeat (5) @(posedge clk);
    #1;
    outs = {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error};
    n_cmp++;
    if (outs !== 24'd0 || wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got outs=%h writes=%0d expected 000000 and 0", outs, wr_log.size());
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_load();
    int n;
    int bad;
    int first_bad;
    logic [7:0] x;
    logic [7:0] img [1024];
    bit bub;
    bit poke;
    for (int sc = 0; sc < 7; sc++) begin
      do_reset();
      stim_q.delete();
      bub  = 1'b0;
      poke = 1'b0;
      if (sc <= 2) begin
        foreach (fixed_stream[i]) stim_q.push_back(fixed_stream[i]);
        bub  = (sc == 1);
        poke = (sc == 2);
      end else begin
        n = (sc == 5) ? 256 : (sc == 6) ? 1 : int'($urandom_range(1, 6));
        stim_q.push_back(8'(n));
        stim_q.push_back(8'(n >> 8));
        x = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
          stim_q.push_back(8'($urandom_range(0, 255)));
          x = x ^ stim_q[stim_q.size() - 1];
        end
        stim_q.push_back(x);
        bub = (sc != 5) && ($urandom_range(0, 1) == 1);
      end
      drive_session(bub, poke, stim_q.size());
      build_model();

      n_cmp++;
      if (stalled !== 1'b0 || {hold_s, busy_s} !== 2'b11) begin
        n_fail++;
        $display("FAIL load%0d_session: stalled=%0b hold/busy=%b expected 0 and 11", sc, stalled, {hold_s, busy_s});
      end
      n_cmp++;
      if (wr_log.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL load%0d_write_count: got %0d expected %0d", sc, wr_log.size(), exp_q.size());
      end
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < 1024 && i < wr_log.size(); i++) begin
        if ({wr_log[i].addr, wr_log[i].data} !== exp_q[i] || wr_log[i].cyc != start_cyc + 1 + i) begin
          bad++;
          if (first_bad < 0) first_bad = i;
        end
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL load%0d_clear_seq: %0d bad entries, first at %0d, expected 0", sc, bad, first_bad);
      end
      for (int k = 0; k < exp_n; k++) begin
        if (1024 + k < wr_log.size()) begin
          n_cmp++;
          if ({wr_log[1024 + k].addr, wr_log[1024 + k].data} !== exp_q[1024 + k] ||
              wr_log[1024 + k].cyc != exp_cyc_q[k]) begin
            n_fail++;
            $display("FAIL load%0d_data%0d: got addr=%0d data=%h cyc=%0d expected addr=%0d data=%h cyc=%0d",
                     sc, k, wr_log[1024 + k].addr, wr_log[1024 + k].data, wr_log[1024 + k].cyc,
                     exp_q[1024 + k][17:8], exp_q[1024 + k][7:0], exp_cyc_q[k]);
          end
        end
      end
      for (int a = 0; a < 1024; a++) img[a] = 8'hxx;
      foreach (wr_log[i]) img[wr_log[i].addr] = wr_log[i].data;
      bad = 0;
      first_bad = -1;
      for (int a = 0; a < 1024; a++) begin
        if (img[a] !== mem_model[a]) begin
          bad++;
          if (first_bad < 0) first_bad = a;
        end
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL load%0d_mem_image: %0d bad bytes, first at %0d, expected 0", sc, bad, first_bad);
      end
      n_cmp++;
      if (done_log.size() != (exp_ok ? 1 : 0) ||
          (done_log.size() == 1 && acc_q.size() > 0 && done_log[0] != acc_q[acc_q.size() - 1] + 1)) begin
        n_fail++;
        $display("FAIL load%0d_done_pulse: got %0d pulses expected %0d one cycle after last accept",
                 sc, done_log.size(), exp_ok ? 1 : 0);
      end
      n_cmp++;
      if ({cpu_hold, busy, error, rx_ready} !== (exp_ok ? 4'b0000 : 4'b1010)) begin
        n_fail++;
        $display("FAIL load%0d_end_flags: got hold/busy/err/rdy=%b expected %b",
                 sc, {cpu_hold, busy, error, rx_ready}, exp_ok ? 4'b0000 : 4'b1010);
      end
    end
  endtask

  task automatic test_bad_checksum();
    int nw;
    do_reset();
    stim_q.delete();
    foreach (fixed_stream[i]) stim_q.push_back(fixed_stream[i]);
    stim_q[10] = 8'h40;
    drive_session(1'b0, 1'b0, stim_q.size());
    build_model();
    n_cmp++;
    if (wr_log.size() != exp_q.size() || exp_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL badsum_writes: got %0d expected %0d (model ok=%0b)", wr_log.size(), exp_q.size(), exp_ok);
    end
    n_cmp++;
    if ({error, cpu_hold, busy, done_log.size() == 0} !== 4'b1101) begin
      n_fail++;
      $display("FAIL badsum_flags: got err/hold/busy/nodone=%b expected 1101",
               {error, cpu_hold, busy, done_log.size() == 0});
    end
    nw = wr_log.size();
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (rx_ready !== 1'b0 || error !== 1'b1 || wr_log.size() != nw) begin
      n_fail++;
      $display("FAIL badsum_sticky: got rdy=%b err=%b writes=%0d expected 0 1 %0d", rx_ready, error, wr_log.size(), nw);
    end
    rx_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({error, mem_we, busy, cpu_hold} !== 4'b0111 || mem_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL badsum_restart: got err/we/busy/hold=%b addr=%0d expected 0111 addr=0",
               {error, mem_we, busy, cpu_hold}, mem_addr);
    end
  endtask

  task automatic test_bad_length();
    for (int sc = 0; sc < 2; sc++) begin
      do_reset();
      stim_q.delete();
      stim_q.push_back(sc == 0 ? 8'h00 : 8'h01);
      stim_q.push_back(sc == 0 ? 8'h00 : 8'h01);
      drive_session(1'b0, 1'b0, 2);
      build_model();
      n_cmp++;
      if (stalled !== 1'b0 || wr_log.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL badlen%0d_writes: got %0d stalled=%0b expected %0d", sc, wr_log.size(), stalled, exp_q.size());
      end
      n_cmp++;
      if ({error, cpu_hold, rx_ready, busy} !== 4'b1100) begin
        n_fail++;
        $display("FAIL badlen%0d_flags: got err/hold/rdy/busy=%b expected 1100", sc, {error, cpu_hold, rx_ready, busy});
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] outs;
    logic [7:0] x;
    int nw;
    do_reset();
    stim_q.delete();
    stim_q.push_back(8'h04);
    stim_q.push_back(8'h00);
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      stim_q.push_back(8'($urandom_range(0, 255)));
      x = x ^ stim_q[stim_q.size() - 1];
    end
    stim_q.push_back(x);
    drive_session(1'b0, 1'b0, 5);
    #1 reset_n = 1'b0;
    #1;
    outs = {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error};
    n_cmp++;
    if (outs !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %h expected 000000", outs);
    end
    nw = wr_log.size();
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    outs = {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error};
    n_cmp++;
    if (wr_log.size() != nw || outs !== 24'd0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got writes=%0d outs=%h expected %0d and 000000", wr_log.size(), outs, nw);
    end
    rx_valid = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_bad_checksum();
    test_bad_length();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
